// File: rtl/q_sys_pll_seq_pkg.sv
// Shared types and helpers for the PLL powerdown sequencer: state encoding,
// retry counter width and the sequencing counter width.
package q_sys_pll_seq_pkg;

    localparam int RETRY_W = 8;

    typedef enum logic [1:0] {
        POWERDOWN,
        WAIT_LOCK,
        FILTER,
        LOCKED
    } pll_seq_state_t;

    // The counter only has to reach (largest cycle parameter - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/q_sys_pll_seq_sync.sv
// Multi-flop synchronizer for a single asynchronous level (PLL lock status).
module q_sys_pll_seq_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/q_sys_pll_powerdown_sequencer.sv
// PLL powerdown / lock-qualification sequencer with timeout and loss-of-lock retry.
// Define PLL_SEQ_LOCK_SYNC_EN to pass pll_locked through a 2-flop synchronizer.
module q_sys_pll_powerdown_sequencer
    import q_sys_pll_seq_pkg::*;
#(
    parameter int POWERDOWN_CYCLES    = 1000,
    parameter int LOCK_FILTER_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_locked,
    input  logic               req_reset,
    output logic               pll_powerdown,
    output logic               pll_locked_stable,
    output logic               timeout_err,
    output logic               lol_err,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int CW = cnt_width(POWERDOWN_CYCLES, LOCK_FILTER_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam logic [CW-1:0] PD_LAST     = CW'(POWERDOWN_CYCLES - 1);
    localparam logic [CW-1:0] FILTER_LAST = CW'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);

    logic           lock_s;
    pll_seq_state_t state;
    logic [CW-1:0]  cnt;

`ifdef PLL_SEQ_LOCK_SYNC_EN
    q_sys_pll_seq_sync #(
        .DEPTH(2)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_locked),
        .q     (lock_s)
    );
`else
    assign lock_s = pll_locked;
`endif

    // Outputs are updated together with the state so they reflect the new state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= POWERDOWN;
            cnt               <= '0;
            pll_powerdown     <= 1'b1;
            pll_locked_stable <= 1'b0;
            timeout_err       <= 1'b0;
            lol_err           <= 1'b0;
            retry_count       <= '0;
        end else begin
            timeout_err <= 1'b0;
            lol_err     <= 1'b0;
            if (req_reset) begin
                state             <= POWERDOWN;
                cnt               <= '0;
                pll_powerdown     <= 1'b1;
                pll_locked_stable <= 1'b0;
            end else begin
                case (state)
                    POWERDOWN: begin
                        if (cnt == PD_LAST) begin
                            state         <= WAIT_LOCK;
                            cnt           <= '0;
                            pll_powerdown <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= FILTER;
                            cnt   <= '0;
                        end else if (cnt == TO_LAST) begin
                            state         <= POWERDOWN;
                            cnt           <= '0;
                            pll_powerdown <= 1'b1;
                            timeout_err   <= 1'b1;
                            if (retry_count != '1) retry_count <= retry_count + 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    FILTER: begin
                        if (!lock_s) begin
                            state <= WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == FILTER_LAST) begin
                            state             <= LOCKED;
                            cnt               <= '0;
                            pll_locked_stable <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (!lock_s) begin
                            state             <= POWERDOWN;
                            cnt               <= '0;
                            pll_powerdown     <= 1'b1;
                            pll_locked_stable <= 1'b0;
                            lol_err           <= 1'b1;
                            if (retry_count != '1) retry_count <= retry_count + 1'b1;
                        end
                    end
                    default: begin
                        state         <= POWERDOWN;
                        cnt           <= '0;
                        pll_powerdown <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_q_sys_pll_powerdown_sequencer.sv
// Self-checking bench: vector table, corner-case sequences and randomized lock
// activity, all compared against a timestamp-based reference model.
module tb_q_sys_pll_powerdown_sequencer;

    localparam int PD = 8;
    localparam int F  = 4;
    localparam int TO = 32;
`ifdef PLL_SEQ_LOCK_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       req_reset = 1'b0;
    logic       pll_powerdown;
    logic       pll_locked_stable;
    logic       timeout_err;
    logic       lol_err;
    logic [7:0] retry_count;

    q_sys_pll_powerdown_sequencer #(
        .POWERDOWN_CYCLES    (PD),
        .LOCK_FILTER_CYCLES  (F),
        .LOCK_TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pll_locked        (pll_locked),
        .req_reset         (req_reset),
        .pll_powerdown     (pll_powerdown),
        .pll_locked_stable (pll_locked_stable),
        .timeout_err       (timeout_err),
        .lol_err           (lol_err),
        .retry_count       (retry_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n = 0;

    // Reference model: phase 0 = powered down until edge pd_end, 1 = waiting
    // (run = consecutive lock samples), 2 = locked.
    int   m_ph = 0;
    int   pd_end = 0;
    int   wait_start = 0;
    int   run = 0;
    int   m_retry = 0;
    logic m_to = 1'b0;
    logic m_lol = 1'b0;
    logic hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
        end
    endtask

    task automatic restart_pd();
        m_ph   = 0;
        pd_end = n + PD;
        run    = 0;
    endtask

    task automatic model_edge(input logic r, input logic l, input logic q);
        logic ls;
        m_to  = 1'b0;
        m_lol = 1'b0;
        if (r) begin
            restart_pd();
            m_retry = 0;
            hist.delete();
            for (int i = 0; i < SL; i++) hist.push_back(1'b0);
            return;
        end
        if (SL == 0) begin
            ls = l;
        end else begin
            ls = hist.pop_front();
            hist.push_back(l);
        end
        if (q) begin
            restart_pd();
            return;
        end
        if (m_ph == 0) begin
            if (n == pd_end) begin
                m_ph = 1;
                wait_start = n;
                run = 0;
            end
        end else if (m_ph == 1) begin
            if (ls) begin
                run++;
                if (run == F + 1) m_ph = 2;
            end else if (run > 0) begin
                run = 0;
                wait_start = n;
            end else if (n - wait_start == TO) begin
                m_to = 1'b1;
                if (m_retry < 255) m_retry++;
                restart_pd();
            end
        end else begin
            if (!ls) begin
                m_lol = 1'b1;
                if (m_retry < 255) m_retry++;
                restart_pd();
            end
        end
    endtask

    task automatic step();
        logic r, l, q;
        r = reset;
        l = pll_locked;
        q = req_reset;
        @(posedge clk);
        n++;
        model_edge(r, l, q);
        #1;
        chk("pd", pll_powerdown, (m_ph == 0));
        chk("stable", pll_locked_stable, (m_ph == 2));
        chk("timeout_err", timeout_err, m_to);
        chk("lol_err", lol_err, m_lol);
        chk("retry", retry_count, m_retry);
    endtask

    typedef struct {
        logic rst;
        logic lk;
        logic req;
        int   cyc;
        logic e_pd;
        logic e_st;
        logic e_to;
        logic e_lol;
        int   e_retry;
    } vec_t;

    vec_t vt[15];

    initial begin
        int hi;
        int t;
        int hold;

        vt[0]  = '{1'b1, 1'b0, 1'b0, 2,      1'b1, 1'b0, 1'b0, 1'b0, 0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, PD - 1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1,      1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 5,      1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, SL + F, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1,      1'b0, 1'b1, 1'b0, 1'b0, 0};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 10,     1'b0, 1'b1, 1'b0, 1'b0, 0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, SL,     1'b0, 1'b1, 1'b0, 1'b0, 0};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 1,      1'b1, 1'b0, 1'b0, 1'b1, 1};
        vt[9]  = '{1'b0, 1'b0, 1'b0, PD - 1, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1,      1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[11] = '{1'b0, 1'b0, 1'b0, TO - 1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        vt[12] = '{1'b0, 1'b0, 1'b0, 1,      1'b1, 1'b0, 1'b1, 1'b0, 2};
        vt[13] = '{1'b0, 1'b0, 1'b1, 5,      1'b1, 1'b0, 1'b0, 1'b0, 2};
        vt[14] = '{1'b1, 1'b0, 1'b0, 1,      1'b1, 1'b0, 1'b0, 1'b0, 0};

        #2;
        for (int v = 0; v < 15; v++) begin
            reset      = vt[v].rst;
            pll_locked = vt[v].lk;
            req_reset  = vt[v].req;
            repeat (vt[v].cyc) step();
            chk("vec_pd", pll_powerdown, vt[v].e_pd);
            chk("vec_stable", pll_locked_stable, vt[v].e_st);
            chk("vec_timeout", timeout_err, vt[v].e_to);
            chk("vec_lol", lol_err, vt[v].e_lol);
            chk("vec_retry", retry_count, vt[v].e_retry);
            $display("vec %0d rst=%0b lk=%0b req=%0b cyc=%0d -> pd=%0b stable=%0b to=%0b lol=%0b retry=%0d",
                     v, vt[v].rst, vt[v].lk, vt[v].req, vt[v].cyc, pll_powerdown,
                     pll_locked_stable, timeout_err, lol_err, retry_count);
        end

        // Collision: req_reset on the timeout-expiry edge wins.
        reset = 1'b0;
        req_reset = 1'b0;
        pll_locked = 1'b0;
        repeat (PD) step();
        repeat (TO - 1) step();
        req_reset = 1'b1;
        step();
        req_reset = 1'b0;
        chk("collision_to", timeout_err, 1'b0);
        chk("collision_retry", retry_count, 0);
        hi = 1;
        for (int i = 0; i < 2 * PD && pll_powerdown; i++) begin
            step();
            if (pll_powerdown) hi++;
        end
        chk("collision_pd_len", hi, PD);
        $display("collision: timeout_err=%0b retry=%0d pd_len=%0d", timeout_err, retry_count, hi);

        // Glitch in WAIT_LOCK restarts the timeout budget.
        repeat (3) step();
        pll_locked = 1'b1;
        repeat (2) step();
        pll_locked = 1'b0;
        t = 0;
        for (int i = 0; i < TO + 20; i++) begin
            step();
            t++;
            if (timeout_err) break;
        end
        chk("glitch_to_delay", t, SL + 1 + TO);
        $display("glitch: timeout after %0d cycles, retry=%0d", t, retry_count);

        // Saturation: each retry period is PD + TO cycles with no lock.
        for (int i = 0; i < 300; i++) repeat (PD + TO) step();
        chk("sat_retry", retry_count, 255);
        $display("saturation: retry=%0d", retry_count);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("sat_reset_retry", retry_count, 0);
        $display("saturation reset: retry=%0d", retry_count);

        // Randomized lock activity with occasional software re-sequence.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                pll_locked = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 50);
            end
            hold--;
            req_reset = ($urandom_range(0, 99) == 0);
            step();
        end
        req_reset = 1'b0;
        $display("random: 3000 cycles, retry=%0d", retry_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/q_sys_pll_powerdown_sequencer.md
# q_sys_pll_powerdown_sequencer

Sequences powerdown and lock qualification for one transceiver PLL. It drives the PLL powerdown request into the PLL status interconnect and consumes the fanned-out `pll_locked` status returned from it. It enforces a minimum powerdown pulse, waits for lock with a timeout, and debounces lock. It re-sequences automatically on timeout or loss of lock, and presents a clean `pll_locked_stable` to downstream transceiver reset logic.

## Interface
- `POWERDOWN_CYCLES`, default 1000: cycles `pll_powerdown` is held high per sequence; minimum 2.
- `LOCK_FILTER_CYCLES`, default 256: consecutive cycles of lock required before `pll_locked_stable` asserts; minimum 1.
- `LOCK_TIMEOUT_CYCLES`, default 100000: cycles allowed in WAIT_LOCK before a retry; minimum 2.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `pll_locked`  in  1  PLL lock status from the interconnect; asynchronous to `clk`.
- `req_reset`  in  1  single-cycle software request to re-sequence.
- `pll_powerdown`  out  1  registered powerdown request to the interconnect.
- `pll_locked_stable`  out  1  registered qualified lock.
- `timeout_err`  out  1  one-cycle pulse when the lock timeout expires.
- `lol_err`  out  1  one-cycle pulse on loss of lock from LOCKED.
- `retry_count`  out  8  saturating count of automatic re-sequences.

## Operation
- The state machine has four states: POWERDOWN, WAIT_LOCK, FILTER, LOCKED.
- `lock_s` is `pll_locked` after the optional synchronizer. Counter `cnt` is shared by all states and is cleared on every state transition.
- **Reset values:** state=POWERDOWN, cnt=0, `pll_powerdown`=1, `pll_locked_stable`=0, `timeout_err`=0, `lol_err`=0, `retry_count`=0, synchronizer flops=0.
- **POWERDOWN:** `pll_powerdown`=1.
  - When cnt==POWERDOWN_CYCLES-1, go to WAIT_LOCK.
- **WAIT_LOCK:** `pll_powerdown`=0.
  - If `lock_s`=1, go to FILTER.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1: pulse `timeout_err`, increment `retry_count`, go to POWERDOWN.
- **FILTER:**
  - If `lock_s`=0, return to WAIT_LOCK. The timeout budget restarts.
  - If cnt==LOCK_FILTER_CYCLES-1 with `lock_s`=1, go to LOCKED.
- **LOCKED:** `pll_locked_stable`=1.
  - If `lock_s`=0: pulse `lol_err`, increment `retry_count`, go to POWERDOWN.
- **`req_reset` in any state:** go to POWERDOWN next cycle with cnt cleared.
  - `retry_count` is not incremented and no error pulse is issued.
  - This has priority over simultaneous timeout or loss of lock, which are then suppressed.
- `retry_count` saturates at 255. It is cleared only by `reset`.
- Counter width is clog2 of the largest parameter. Compares are exact equality on unsigned values; no wrap is possible.

## Timing
- All outputs are registered and change on the cycle after the state transition.
- From `reset` deassertion, `pll_powerdown` stays high for exactly POWERDOWN_CYCLES cycles.
- Lock latency (with sync): `pll_locked` rising to `pll_locked_stable` rising is 2 + LOCK_FILTER_CYCLES + 1 cycles. Without sync it is LOCK_FILTER_CYCLES + 1.
- Loss-of-lock latency (with sync): `pll_locked` falling to `pll_locked_stable` falling is 3 cycles. On that same cycle, `pll_powerdown` rises and `lol_err` pulses.
- `reset` asserted mid-sequence: all outputs return to reset values on the next edge. An in-flight pulse is truncated.
- `req_reset` held high: the block stays in POWERDOWN with cnt held at 0.

## Configuration
- `PLL_SEQ_LOCK_SYNC_EN` defined: `pll_locked` passes through a 2-flop synchronizer before the state machine.
- Undefined: `lock_s` = `pll_locked` directly, for use when the lock is already synchronous. Latencies shrink by 2 cycles; all other behaviour is identical.

## Structure
- Package `q_sys_pll_seq_pkg` holds:
  - the state enum `pll_seq_state_t` (POWERDOWN, WAIT_LOCK, FILTER, LOCKED);
  - the `RETRY_W`=8 constant;
  - a counter-width function taking the max of the three parameters.
- Sub-module `q_sys_pll_seq_sync`: parameterized-depth synchronizer, instantiated only under `PLL_SEQ_LOCK_SYNC_EN`.

## Test plan
Parameters for all scenarios: POWERDOWN_CYCLES=8, LOCK_FILTER_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, sync enabled.
1. **Basic lock:** release reset, raise `pll_locked` 5 cycles after `pll_powerdown` falls -> `pll_powerdown` high exactly 8 cycles; `pll_locked_stable` rises 7 cycles after `pll_locked`; `retry_count`=0.
2. **Timeout:** hold `pll_locked`=0 -> `timeout_err` pulses 32 cycles after `pll_powerdown` falls; `pll_powerdown` high again for 8 cycles; `retry_count`=1; repeats each 40 cycles.
3. **Glitch:** pulse `pll_locked` high 2 cycles in WAIT_LOCK -> `pll_locked_stable` stays 0; no `timeout_err` earlier than 32 cycles after the glitch ends.
4. **Loss of lock:** drop `pll_locked` in LOCKED -> 3 cycles later `pll_locked_stable`=0, `lol_err` pulses, `pll_powerdown`=1; `retry_count` increments.
5. **Collision:** assert `req_reset` on the timeout-expiry cycle -> no `timeout_err`, `retry_count` unchanged, `pll_powerdown` high for 8 cycles.
6. **Saturation:** force 300 timeouts -> `retry_count` holds at 255; `reset` clears it to 0.
